// File: rtl/pwm_pkg.sv
// pwm_pkg: shared limits and channel-index width helper for the PWM bank
package pwm_pkg;
  localparam int PWM_CH_MAX = 16;
  function automatic int chan_idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: shadow/active duty pair, compare against next count, polarity, registered output (clk, rst, en, wrap, we, wr_duty, cnt_nxt, pol -> pwm)
module pwm_channel #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         wrap,
  input  logic         we,
  input  logic [W-1:0] wr_duty,
  input  logic [W-1:0] cnt_nxt,
  input  logic         pol,
  output logic         pwm
);
  logic [W-1:0] duty_sh, duty_act, act_nxt;
  assign act_nxt = !en || wrap ? duty_sh : duty_act;
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_sh  <= '0;
      duty_act <= '0;
      pwm      <= 1'b0;
    end else begin
      if (we) duty_sh <= wr_duty;
      duty_act <= act_nxt;
      pwm      <= en ? (cnt_nxt < act_nxt) ^ pol : pol;
    end
  end
endmodule

// File: rtl/pwm_bank.sv
// pwm_bank: CH-channel PWM on a shared prescaled timebase with wrap-buffered duty/period (CLK, RST, EN, DIV, PERIOD, WR/WR_CH/WR_DUTY, POL -> PWM_OUT, PERIOD_END)
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int CH    = 4,
  parameter int W     = 8,
  parameter int PSC_W = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     EN,
  input  logic [PSC_W-1:0]         DIV,
  input  logic [W-1:0]             PERIOD,
  input  logic                     WR,
  input  logic [chan_idx_w(CH)-1:0] WR_CH,
  input  logic [W-1:0]             WR_DUTY,
  input  logic [CH-1:0]            POL,
  output logic [CH-1:0]            PWM_OUT,
  output logic                     PERIOD_END
);
  localparam int IW = chan_idx_w(CH);
  logic [PSC_W-1:0] psc;
  logic [W-1:0]     cnt, cnt_nxt, per_act;
  logic             tick, wrap;
  assign tick    = EN && psc == DIV;
  assign wrap    = tick && cnt == per_act;
  assign cnt_nxt = !EN || wrap ? '0 : tick ? cnt + 1'b1 : cnt;
  always_ff @(posedge CLK) begin
    if (RST) begin
      psc        <= '0;
      cnt        <= '0;
      per_act    <= '0;
      PERIOD_END <= 1'b0;
    end else begin
      psc        <= !EN || tick ? '0 : psc + 1'b1;
      cnt        <= cnt_nxt;
      per_act    <= !EN || wrap ? PERIOD : per_act;
      PERIOD_END <= wrap;
    end
  end
  for (genvar i = 0; i < CH; i++) begin : g_ch
    pwm_channel #(.W(W)) u_ch (
      .clk    (CLK),
      .rst    (RST),
      .en     (EN),
      .wrap   (wrap),
      .we     (WR && WR_CH == IW'(i)),
      .wr_duty(WR_DUTY),
      .cnt_nxt(cnt_nxt),
      .pol    (POL[i]),
      .pwm    (PWM_OUT[i])
    );
  end
endmodule
